// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the ID-stage branch resolver: branch opcodes,
// FSM state encoding and the operand-readiness rule.
package branch_resolver_pkg;

    localparam logic [2:0] BR_OP_BEQ  = 3'd0;
    localparam logic [2:0] BR_OP_BNE  = 3'd1;
    localparam logic [2:0] BR_OP_BLEZ = 3'd2;
    localparam logic [2:0] BR_OP_BGTZ = 3'd3;
    localparam logic [2:0] BR_OP_BLTZ = 3'd4;
    localparam logic [2:0] BR_OP_BGEZ = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REDIRECT
    } br_state_e;

    // Only BEQ/BNE consume rt; the rest compare rs against zero.
    function automatic logic ops_ready(input logic [2:0] op,
                                       input logic       rs_rdy,
                                       input logic       rt_rdy);
        return rs_rdy && (rt_rdy || (op > BR_OP_BNE));
    endfunction

endpackage

// File: rtl/branch_resolver_cond.sv
// Combinational branch condition evaluation. Signed two's-complement
// tests against zero for the REGIMM/BLEZ/BGTZ family; reserved ops are
// never taken.
module branch_cond
    import branch_resolver_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2:0]        br_op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic              taken
);

    logic ge;
    logic zero;

    assign ge   = !rs_val[DATA_W-1];
    assign zero = (rs_val == '0);

    // Select the condition for the current opcode.
    always_comb begin
        taken = 1'b0;
        case (br_op)
            BR_OP_BEQ:  taken = (rs_val == rt_val);
            BR_OP_BNE:  taken = (rs_val != rt_val);
            BR_OP_BLEZ: taken = !ge || zero;
            BR_OP_BGTZ: taken = ge && !zero;
            BR_OP_BLTZ: taken = !ge;
            BR_OP_BGEZ: taken = ge;
            default:    taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// ID-stage branch resolver: waits for forwarded operands (bounded by a
// watchdog), evaluates the branch and issues a registered one-cycle PC
// redirect. Optional statistics counters are built when BR_STATS_EN is
// defined; otherwise br_total/br_taken are tied to zero.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              br_valid,
    input  logic [2:0]        br_op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              rs_ready,
    input  logic              rt_ready,
    input  logic [ADDR_W-1:0] pc_id,
    input  logic [15:0]       imm16,
    output logic              stall,
    output logic              redirect_vld,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              hazard_err,
    output logic [31:0]       br_total,
    output logic [31:0]       br_taken
);

    localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

    br_state_e         state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              hazard_q, hazard_d;
    logic [ADDR_W-1:0] target_q, target_d;

    logic              ready;
    logic              taken;
    logic              resolve;
    logic              stall_c;
    logic [ADDR_W-1:0] target;

    assign ready  = ops_ready(br_op, rs_ready, rt_ready);
    assign target = pc_id + ADDR_W'(32'd4) + ADDR_W'($signed({imm16, 2'b00}));

    branch_cond #(.DATA_W(DATA_W)) u_cond (
        .br_op  (br_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .taken  (taken)
    );

    // Next-state, watchdog and resolve decode; flush overrides everything.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        hazard_d   = hazard_q;
        target_d   = target_q;
        stall_c    = 1'b0;
        resolve    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!flush && br_valid) begin
                    if (ready) begin
                        resolve = 1'b1;
                    end else begin
                        stall_c    = 1'b1;
                        state_d    = ST_WAIT;
                        wait_cnt_d = '0;
                    end
                end
            end
            ST_WAIT: begin
                wait_cnt_d = '0;
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (ready) begin
                    resolve = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    // wait_cnt counts completed WAIT cycles; this one brings it to WAIT_MAX.
                    if (wait_cnt_q == CNT_W'(WAIT_MAX - 1)) begin
                        hazard_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_REDIRECT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (resolve) begin
            state_d = taken ? ST_REDIRECT : ST_IDLE;
            if (taken) begin
                target_d = target;
            end
        end
    end

    // State, watchdog counter, sticky error and latched target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            hazard_q   <= 1'b0;
            target_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            hazard_q   <= hazard_d;
            target_q   <= target_d;
        end
    end

    assign stall        = stall_c && rst_n;
    assign redirect_vld = (state_q == ST_REDIRECT);
    assign redirect_pc  = target_q;
    assign hazard_err   = hazard_q;

`ifdef BR_STATS_EN
    logic [31:0] br_total_q;
    logic [31:0] br_taken_q;

    // Count resolved and taken branches; wraps at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_total_q <= '0;
            br_taken_q <= '0;
        end else begin
            if (resolve) begin
                br_total_q <= br_total_q + 32'd1;
            end
            if (resolve && taken) begin
                br_taken_q <= br_taken_q + 32'd1;
            end
        end
    end

    assign br_total = br_total_q;
    assign br_taken = br_taken_q;
`else
    assign br_total = '0;
    assign br_taken = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed testbench for branch_resolver: redirect latency and target,
// signed conditions, operand stall, watchdog, flush, async reset, wrap.
module tb_branch_resolver;

    import branch_resolver_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        br_valid;
    logic [2:0]  br_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        rs_ready;
    logic        rt_ready;
    logic [31:0] pc_id;
    logic [15:0] imm16;
    logic        stall;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic        hazard_err;
    logic [31:0] br_total;
    logic [31:0] br_taken;

    int n_checks = 0;
    int n_pass   = 0;

    branch_resolver #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .WAIT_MAX (15)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .br_valid     (br_valid),
        .br_op        (br_op),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .rs_ready     (rs_ready),
        .rt_ready     (rt_ready),
        .pc_id        (pc_id),
        .imm16        (imm16),
        .stall        (stall),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .hazard_err   (hazard_err),
        .br_total     (br_total),
        .br_taken     (br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_br(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                            input logic [31:0] pc, input logic [15:0] imm);
        br_valid = 1'b1;
        br_op    = op;
        rs_val   = rs;
        rt_val   = rt;
        pc_id    = pc;
        imm16    = imm;
        rs_ready = 1'b1;
        rt_ready = 1'b1;
    endtask

    logic [2:0]  t2_op  [3] = '{BR_OP_BGEZ, BR_OP_BGTZ, BR_OP_BLEZ};
    logic [31:0] t2_rs  [3] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0};
    logic        t2_exp [3] = '{1'b0, 1'b1, 1'b1};

    logic [2:0]  x_op  [8] = '{BR_OP_BLTZ, BR_OP_BLTZ, BR_OP_BNE, BR_OP_BEQ,
                               3'd6, 3'd7, BR_OP_BLEZ, BR_OP_BGTZ};
    logic [31:0] x_rs  [8] = '{32'hFFFF_FFFF, 32'h0, 32'h3, 32'h3,
                               32'h5, 32'h5, 32'h8000_0000, 32'h0};
    logic [31:0] x_rt  [8] = '{32'h0, 32'h0, 32'h3, 32'h4,
                               32'h5, 32'h6, 32'h0, 32'h0};
    logic        x_exp [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    int stalls;
    int redirs;

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        br_valid = 1'b0;
        br_op    = '0;
        rs_val   = '0;
        rt_val   = '0;
        rs_ready = 1'b0;
        rt_ready = 1'b0;
        pc_id    = '0;
        imm16    = '0;
        #2;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_vld", 32'(redirect_vld), 32'd0);
        check("rst_pc", redirect_pc, 32'd0);
        check("rst_hazard", 32'(hazard_err), 32'd0);
        check("rst_total", br_total, 32'd0);
        check("rst_taken", br_taken, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: ready BEQ, one-cycle redirect latency
        drive_br(BR_OP_BEQ, 32'h5, 32'h5, 32'h3000, 16'h0004);
        @(negedge clk);
        check("t1_stall", 32'(stall), 32'd0);
        tick();
        br_valid = 1'b0;
        check("t1_vld", 32'(redirect_vld), 32'd1);
        check("t1_pc", redirect_pc, 32'h3014);
        @(negedge clk);
        check("t1_stall2", 32'(stall), 32'd0);
        tick();
        check("t1_vld_pulse", 32'(redirect_vld), 32'd0);

        // 2: signed conditions against zero
        for (int i = 0; i < 3; i++) begin
            drive_br(t2_op[i], t2_rs[i], 32'h0, 32'h3000, 16'h0000);
            tick();
            br_valid = 1'b0;
            check($sformatf("t2_vld_%0d", i), 32'(redirect_vld), 32'(t2_exp[i]));
            if (t2_exp[i])
                check($sformatf("t2_pc_%0d", i), redirect_pc, 32'h3004);
            tick();
        end
`ifdef BR_STATS_EN
        check("t2_total", br_total, 32'd4);
        check("t2_taken", br_taken, 32'd3);
`else
        check("t2_total", br_total, 32'd0);
        check("t2_taken", br_taken, 32'd0);
`endif

        // 3: BNE with rt late by 3 cycles, negative offset
        drive_br(BR_OP_BNE, 32'h1, 32'h2, 32'h1000, 16'hFFFF);
        rt_ready = 1'b0;
        stalls = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (stall) stalls++;
            tick();
        end
        rt_ready = 1'b1;
        @(negedge clk);
        check("t3_stall_ready", 32'(stall), 32'd0);
        tick();
        br_valid = 1'b0;
        check("t3_stalls", 32'(stalls), 32'd3);
        check("t3_vld", 32'(redirect_vld), 32'd1);
        check("t3_pc", redirect_pc, 32'h1000);
        tick();

        // 4: watchdog after 16 stalled cycles
        drive_br(BR_OP_BGEZ, 32'h0, 32'h0, 32'h2000, 16'h0000);
        rs_ready = 1'b0;
        stalls = 0;
        redirs = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (redirect_vld) redirs++;
            if (i == 15) check("t4_hazard_early", 32'(hazard_err), 32'd0);
            tick();
        end
        br_valid = 1'b0;
        rs_ready = 1'b1;
        check("t4_hazard", 32'(hazard_err), 32'd1);
        check("t4_stalls", 32'(stalls), 32'd16);
        check("t4_redirs", 32'(redirs), 32'd0);
        @(negedge clk);
        check("t4_stall_drop", 32'(stall), 32'd0);
        tick();
        check("t4_vld", 32'(redirect_vld), 32'd0);

        // 5a: flush coincident with a taken resolve
        drive_br(BR_OP_BEQ, 32'h7, 32'h7, 32'h3000, 16'h0004);
        flush = 1'b1;
        tick();
        br_valid = 1'b0;
        flush = 1'b0;
        check("t5_flush_vld", 32'(redirect_vld), 32'd0);
        @(negedge clk);
        check("t5_flush_stall", 32'(stall), 32'd0);
        tick();
        check("t5_flush_vld2", 32'(redirect_vld), 32'd0);
        check("t5_hazard_sticky", 32'(hazard_err), 32'd1);
`ifdef BR_STATS_EN
        check("t5_total", br_total, 32'd5);
        check("t5_taken", br_taken, 32'd4);
`else
        check("t5_total", br_total, 32'd0);
        check("t5_taken", br_taken, 32'd0);
`endif

        // 5b: asynchronous reset while in WAIT
        drive_br(BR_OP_BGEZ, 32'h0, 32'h0, 32'h4000, 16'h0000);
        rs_ready = 1'b0;
        tick();
        @(negedge clk);
        check("t5_wait_stall", 32'(stall), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_stall", 32'(stall), 32'd0);
        check("t5_rst_hazard", 32'(hazard_err), 32'd0);
        check("t5_rst_vld", 32'(redirect_vld), 32'd0);
        check("t5_rst_pc", redirect_pc, 32'd0);
        check("t5_rst_total", br_total, 32'd0);
        br_valid = 1'b0;
        rs_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 6: target wrap; branch held into the REDIRECT cycle is ignored
        drive_br(BR_OP_BEQ, 32'h9, 32'h9, 32'hFFFF_FFF8, 16'h0001);
        tick();
        check("t6_vld", 32'(redirect_vld), 32'd1);
        check("t6_pc_wrap", redirect_pc, 32'h0000_0000);
        tick();
        br_valid = 1'b0;
        check("t6_slot_ignored", 32'(redirect_vld), 32'd0);
`ifdef BR_STATS_EN
        check("t6_total", br_total, 32'd1);
        check("t6_taken", br_taken, 32'd1);
`else
        check("t6_total", br_total, 32'd0);
        check("t6_taken", br_taken, 32'd0);
`endif

        // Remaining opcodes, reserved ops and sign boundaries
        for (int i = 0; i < 8; i++) begin
            drive_br(x_op[i], x_rs[i], x_rt[i], 32'h0000_0100, 16'h0010);
            tick();
            br_valid = 1'b0;
            check($sformatf("x_vld_%0d", i), 32'(redirect_vld), 32'(x_exp[i]));
            if (x_exp[i])
                check($sformatf("x_pc_%0d", i), redirect_pc, 32'h0000_0144);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
